frame_bank_arbiter: RTL
=======================

# frame_bank_arbiter

Double-buffered pixel memory arbiter for the 8x8 WS2812 LED matrix. It sits between the display controller, which reads one 24-bit GRB word per pixel while transmitting a frame, and the frame update engine, which writes the next frame. Both share one single-port 128-entry RAM split into two 64-pixel banks. Reads always target the front bank and writes always target the back bank. The banks swap only when the back bank is complete and the display has just finished a frame.

## Interface
- ADDR_W, 6: pixel address width (64 pixels per bank)
- DATA_W, 24: pixel word width (GRB, 8 bits per channel)

- clk  in  1  system clock (12 MHz); all registers update on the falling edge, same as the display controller
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  display read request; single-cycle pulse
- rd_addr  in  ADDR_W  pixel index to read
- rd_data  out  DATA_W  read data; equals mem_rdata; valid only while rd_valid=1
- rd_valid  out  1  registered; high exactly one cycle after a granted rd_req
- wr_req  in  1  update engine write request; held high until wr_ack
- wr_addr  in  ADDR_W  pixel index to write
- wr_data  in  DATA_W  pixel word to write
- wr_ack  out  1  combinational; high in the cycle the write is issued to RAM
- wr_frame_done  in  1  pulse; update engine has finished writing the back bank
- frame_done  in  1  pulse from the display controller at the start of its idle period
- mem_addr  out  ADDR_W+1  RAM address, formed as {bank, pixel}
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, 1-cycle latency
- front_bank  out  1  bank currently being displayed
- swap  out  1  registered one-cycle pulse when front_bank toggles
- missed_frames  out  8  saturating count of frame_done pulses that arrived with no new frame ready

## Operation
- State machine with three states:
  - FILL: the back bank accepts writes.
  - READY: the back bank is complete. Writes are blocked and the block waits for frame_done.
  - SWAP: lasts one cycle. front_bank toggles and swap pulses. The next state is always FILL.
- State transitions:
  - FILL to READY on wr_frame_done.
  - FILL to SWAP if wr_frame_done and frame_done arrive in the same cycle.
  - READY to SWAP on frame_done.
- Arbitration: at most one RAM access per cycle, and reads have strict priority.
  - A rd_req is always granted: mem_addr={front_bank, rd_addr}, mem_we=0.
  - A write is granted only in FILL with rd_req=0: mem_addr={~front_bank, wr_addr}, mem_we=1, wr_ack=1.
  - A write blocked by a read is retried the next cycle. The engine keeps wr_req high.
- A write in the same cycle as wr_frame_done:
  - If the write is granted, it completes and the state still moves on.
  - If wr_req=1 and the write is not granted, wr_frame_done is ignored. Engine protocol requires wr_frame_done only with wr_req=0.
- frame_done arriving in FILL without wr_frame_done: no swap, and missed_frames increments, saturating at 255. The front bank is shown again.
- frame_done arriving in READY or SWAP does not touch missed_frames.
- Reads in the SWAP cycle use the pre-toggle front_bank.
- When no access is granted: mem_we=0, mem_addr holds its last value, and mem_wdata equals wr_data.

## Timing
- Reset values: state=FILL, front_bank=0, swap=0, rd_valid=0, missed_frames=0. wr_ack=0 and mem_we=0 while rst_n=0.
- Asserting rst_n mid-operation aborts any access. A write acked in that cycle is considered lost.
- Read latency: rd_req in cycle N gives rd_valid=1 and rd_data in cycle N+1.
- Write latency: wr_ack and mem_we are asserted in the same cycle as the grant. The engine may present the next write in the following cycle, giving one write per cycle.
- Frame completion to swap:
  - wr_frame_done in cycle N gives state=READY in N+1.
  - frame_done in cycle M (in READY) gives state=SWAP in M+1, with swap=1 and front_bank toggled at the same edge.
  - FILL resumes in M+2.
- Address width: the bank bit is the MSB of mem_addr, so the back-bank address is pixel+64 when front_bank=0.

## Test plan
- Reset, then 64 writes of data i with no reads -> mem_addr=64+i, mem_we=1 and wr_ack=1 every cycle. wr_frame_done -> READY. frame_done -> swap=1 for one cycle and front_bank=1.
- rd_req and wr_req together in FILL with rd_addr=5, wr_addr=9, front_bank=0 -> cycle N: mem_addr=5, wr_ack=0. Cycle N+1: rd_valid=1 and mem_addr=73 with wr_ack=1.
- Three frame_done pulses in FILL -> missed_frames=3 and front_bank unchanged. After 300 pulses -> missed_frames=255.
- wr_req held in READY -> wr_ack stays 0 until the cycle after the swap. The first write then lands at mem_addr=wr_addr, because the back bank is now bank 0.
- Same-cycle wr_frame_done and frame_done in FILL -> swap pulses 1 cycle later and missed_frames is unchanged.
- Drop rst_n mid-fill with state=READY and front_bank=1 -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/frame_bank_arbiter.sv
// Double-buffered pixel RAM arbiter: display reads the front bank, update engine writes the back bank.
// Latency: read data 1 cycle after grant; write acked combinationally in the grant cycle.
// Backpressure: reads always win; a blocked write stalls (wr_ack=0) until a read-free FILL cycle.
module frame_bank_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              wr_frame_done,
  input  logic              frame_done,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              front_bank,
  output logic              swap,
  output logic [7:0]        missed_frames
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              front_bank_q, front_bank_d;
  logic              swap_q, swap_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        missed_q, missed_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;

  logic              rd_bank;
  logic              wr_grant;
  logic              wr_done_eff;

  // The front_bank output toggles on entry to SWAP, but reads during that
  // single cycle still belong to the frame that was being shown.
  assign rd_bank = (state_q == ST_SWAP) ? ~front_bank_q : front_bank_q;

  // Write grant: only while filling, only when no read claims the RAM, never in reset.
  assign wr_grant = rst_n & wr_req & ~rd_req & (state_q == ST_FILL);

  // A frame-done from the engine is honoured only if no write is still pending.
  assign wr_done_eff = wr_frame_done & (~wr_req | wr_grant);

  // RAM port mux: read has priority; idle cycles hold the previous address.
  always_comb begin
    mem_addr   = mem_addr_q;
    mem_we     = 1'b0;
    mem_addr_d = mem_addr_q;
    if (rd_req) begin
      mem_addr = {rd_bank, rd_addr};
    end else if (wr_grant) begin
      mem_addr = {~front_bank_q, wr_addr};
      mem_we   = 1'b1;
    end
    if (rd_req || wr_grant) begin
      mem_addr_d = mem_addr;
    end
  end

  assign wr_ack        = wr_grant;
  assign mem_wdata     = wr_data;
  assign rd_data       = mem_rdata;
  assign rd_valid      = rd_valid_q;
  assign front_bank    = front_bank_q;
  assign swap          = swap_q;
  assign missed_frames = missed_q;

  // Next-state logic for bank control, swap pulse and missed-frame counter.
  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    swap_d       = 1'b0;
    missed_d     = missed_q;
    rd_valid_d   = rd_req;
    case (state_q)
      ST_FILL: begin
        if (wr_done_eff && frame_done) begin
          state_d      = ST_SWAP;
          front_bank_d = ~front_bank_q;
          swap_d       = 1'b1;
        end else if (wr_done_eff) begin
          state_d = ST_READY;
        end else if (frame_done) begin
          // Display repeats the current front bank; note that a frame was lost.
          if (missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
          end
        end
      end
      ST_READY: begin
        if (frame_done) begin
          state_d      = ST_SWAP;
          front_bank_d = ~front_bank_q;
          swap_d       = 1'b1;
        end
      end
      ST_SWAP: begin
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // All state updates on the falling edge, matching the display controller.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      front_bank_q <= 1'b0;
      swap_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      missed_q     <= 8'd0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      swap_q       <= swap_d;
      rd_valid_q   <= rd_valid_d;
      missed_q     <= missed_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

endmodule
